// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch program counter with trap/redirect/stall selection, a
//            circular return-address stack and misaligned-target rejection.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              IALIGN    = 4,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redir_valid,
    input  logic [1:0]      redir_kind,
    input  logic [XLEN-1:0] redir_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus,
    output logic            pc_valid,
    output logic            misalign_err,
    output logic            ras_empty,
    output logic            ras_full
);

    localparam int c_ALIGN_BITS = $clog2(IALIGN);
    localparam int c_PTR_W      = $clog2(RAS_DEPTH);
    localparam int c_CNT_W      = $clog2(RAS_DEPTH + 1);

    localparam logic [c_PTR_W-1:0] c_PTR_MAX = c_PTR_W'(RAS_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(RAS_DEPTH);
    localparam logic [1:0]         c_KIND_CALL = 2'b01;
    localparam logic [1:0]         c_KIND_RET  = 2'b10;

    logic [XLEN-1:0]    r_pc;
    logic               r_valid;
    logic               r_mis;
    logic               r_empty;
    logic               r_full;
    logic [c_PTR_W-1:0] r_ptr;      // next write slot; top entry is r_ptr-1
    logic [c_CNT_W-1:0] r_count;
    logic [XLEN-1:0]    r_ras [RAS_DEPTH];

    logic [XLEN-1:0]    w_pc_plus;
    logic [XLEN-1:0]    w_pc_nxt;
    logic               w_mis_nxt;
    logic               w_push;
    logic [c_PTR_W-1:0] w_ptr_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_PTR_W-1:0] w_ptr_inc;
    logic [c_PTR_W-1:0] w_ptr_dec;

    function automatic logic is_mis(input logic [XLEN-1:0] addr);
        return |addr[c_ALIGN_BITS-1:0];
    endfunction

    assign w_pc_plus = r_pc + XLEN'(IALIGN);
    assign w_ptr_inc = (r_ptr == c_PTR_MAX) ? '0 : r_ptr + c_PTR_W'(1);
    assign w_ptr_dec = (r_ptr == '0) ? c_PTR_MAX : r_ptr - c_PTR_W'(1);

    always_comb begin
        w_pc_nxt  = r_pc;
        w_mis_nxt = 1'b0;
        w_push    = 1'b0;
        w_ptr_nxt = r_ptr;
        w_cnt_nxt = r_count;
        // The first edge out of reset only raises pc_valid so RESET_VEC is fetched.
        if (!r_valid) begin
            w_pc_nxt = r_pc;
        end else if (trap_valid) begin
            if (is_mis(trap_vec)) begin
                w_mis_nxt = 1'b1;
            end else begin
                w_pc_nxt  = trap_vec;
                w_cnt_nxt = '0;
            end
        end else if (redir_valid) begin
            case (redir_kind)
                c_KIND_CALL: begin
                    if (is_mis(redir_target)) begin
                        w_mis_nxt = 1'b1;
                    end else begin
                        w_pc_nxt  = redir_target;
                        w_push    = 1'b1;
                        w_ptr_nxt = w_ptr_inc;
                        w_cnt_nxt = (r_count == c_DEPTH) ? r_count : r_count + c_CNT_W'(1);
                    end
                end
                c_KIND_RET: begin
                    // Stack entries are PC+IALIGN values, so they are always aligned.
                    if (r_count != '0) begin
                        w_pc_nxt  = r_ras[w_ptr_dec];
                        w_ptr_nxt = w_ptr_dec;
                        w_cnt_nxt = r_count - c_CNT_W'(1);
                    end else if (is_mis(redir_target)) begin
                        w_mis_nxt = 1'b1;
                    end else begin
                        w_pc_nxt = redir_target;
                    end
                end
                default: begin
                    if (is_mis(redir_target)) begin
                        w_mis_nxt = 1'b1;
                    end else begin
                        w_pc_nxt = redir_target;
                    end
                end
            endcase
        end else if (!stall) begin
            w_pc_nxt = w_pc_plus;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc    <= RESET_VEC;
            r_valid <= 1'b0;
            r_mis   <= 1'b0;
            r_ptr   <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_valid <= 1'b1;
            r_mis   <= w_mis_nxt;
            r_ptr   <= w_ptr_nxt;
            r_count <= w_cnt_nxt;
            r_empty <= (w_cnt_nxt == '0);
            r_full  <= (w_cnt_nxt == c_DEPTH);
        end
    end

    // Storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_ras[r_ptr] <= w_pc_plus;
        end
    end

    assign PC           = r_pc;
    assign PCPlus       = w_pc_plus;
    assign pc_valid     = r_valid;
    assign misalign_err = r_mis;
    assign ras_empty    = r_empty;
    assign ras_full     = r_full;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed self-checking bench for pc_sequencer (XLEN=32, IALIGN=4,
//            RAS_DEPTH=4, RESET_VEC=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redir_valid;
    logic [1:0]  redir_kind;
    logic [31:0] redir_target;
    logic        trap_valid;
    logic [31:0] trap_vec;
    logic [31:0] PC;
    logic [31:0] PCPlus;
    logic        pc_valid;
    logic        misalign_err;
    logic        ras_empty;
    logic        ras_full;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .XLEN(32), .RESET_VEC(32'h0), .IALIGN(4), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redir_valid(redir_valid), .redir_kind(redir_kind),
        .redir_target(redir_target), .trap_valid(trap_valid),
        .trap_vec(trap_vec), .PC(PC), .PCPlus(PCPlus),
        .pc_valid(pc_valid), .misalign_err(misalign_err),
        .ras_empty(ras_empty), .ras_full(ras_full)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall       = 1'b0;
        redir_valid = 1'b0;
        redir_kind  = 2'b00;
        redir_target = 32'h0;
        trap_valid  = 1'b0;
        trap_vec    = 32'h0;
    endtask

    task automatic redirect(input logic [1:0] kind, input logic [31:0] tgt);
        redir_valid  = 1'b1;
        redir_kind   = kind;
        redir_target = tgt;
        step();
        redir_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        step();
        step();
        reset = 1'b1;
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", PC, 32'h0); end
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", pc_valid); end
        checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0 || misalign_err !== 1'b0) begin
            errors++; $display("FAIL reset_flags got e%b f%b m%b want e1 f0 m0", ras_empty, ras_full, misalign_err); end
        step();
        checks++; if (pc_valid !== 1'b1 || PC !== 32'h0) begin
            errors++; $display("FAIL first_fetch got v%b %h want v1 00000000", pc_valid, PC); end
        step();
        checks++; if (PC !== 32'h4) begin errors++; $display("FAIL adv4 got %h want %h", PC, 32'h4); end
        step();
        checks++; if (PC !== 32'h8 || PCPlus !== 32'hC) begin
            errors++; $display("FAIL adv8 got %h/%h want 00000008/0000000c", PC, PCPlus); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (PC !== 32'h8) begin errors++; $display("FAIL stall_hold%0d got %h want %h", i, PC, 32'h8); end
        end
        redirect(2'b00, 32'h40);
        stall = 1'b0;
        checks++; if (PC !== 32'h40) begin errors++; $display("FAIL stall_redir got %h want %h", PC, 32'h40); end
        step();
        checks++; if (PC !== 32'h44) begin errors++; $display("FAIL post_redir_adv got %h want %h", PC, 32'h44); end
    endtask

    task automatic test_call_return();
        stall = 1'b1;
        redirect(2'b11, 32'h10);
        checks++; if (PC !== 32'h10) begin errors++; $display("FAIL kind11_jump got %h want %h", PC, 32'h10); end
        redirect(2'b01, 32'h100);
        checks++; if (PC !== 32'h100 || ras_empty !== 1'b0) begin
            errors++; $display("FAIL call got %h e%b want 00000100 e0", PC, ras_empty); end
        redirect(2'b10, 32'h0);
        checks++; if (PC !== 32'h14 || ras_empty !== 1'b1) begin
            errors++; $display("FAIL return got %h e%b want 00000014 e1", PC, ras_empty); end
    endtask

    task automatic test_ras_full();
        logic [31:0] exp_ret [4];
        // Calls from 0x14, 0x1000, 0x2000, 0x3000, 0x4000; the oldest (0x18) is overwritten.
        exp_ret[0] = 32'h4004;
        exp_ret[1] = 32'h3004;
        exp_ret[2] = 32'h2004;
        exp_ret[3] = 32'h1004;
        for (int i = 1; i <= 5; i++) begin
            redirect(2'b01, 32'(i) * 32'h1000);
        end
        checks++; if (ras_full !== 1'b1 || ras_empty !== 1'b0 || PC !== 32'h5000) begin
            errors++; $display("FAIL ras_full got f%b e%b %h want f1 e0 00005000", ras_full, ras_empty, PC); end
        for (int i = 0; i < 4; i++) begin
            redirect(2'b10, 32'h0);
            checks++; if (PC !== exp_ret[i]) begin errors++; $display("FAIL ret%0d got %h want %h", i, PC, exp_ret[i]); end
        end
        checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin
            errors++; $display("FAIL ras_drained got e%b f%b want e1 f0", ras_empty, ras_full); end
        redirect(2'b10, 32'h200);
        checks++; if (PC !== 32'h200) begin errors++; $display("FAIL empty_ret got %h want %h", PC, 32'h200); end
    endtask

    task automatic test_misalign();
        redirect(2'b00, 32'h102);
        checks++; if (misalign_err !== 1'b1 || PC !== 32'h200) begin
            errors++; $display("FAIL misalign_jump got m%b %h want m1 00000200", misalign_err, PC); end
        step();
        checks++; if (misalign_err !== 1'b0 || PC !== 32'h200) begin
            errors++; $display("FAIL misalign_clear got m%b %h want m0 00000200", misalign_err, PC); end
        redirect(2'b01, 32'h106);
        checks++; if (misalign_err !== 1'b1 || ras_empty !== 1'b1 || PC !== 32'h200) begin
            errors++; $display("FAIL misalign_call got m%b e%b %h want m1 e1 00000200", misalign_err, ras_empty, PC); end
        redirect(2'b01, 32'h300);
        checks++; if (ras_empty !== 1'b0 || misalign_err !== 1'b0) begin
            errors++; $display("FAIL call_before_trap got e%b m%b want e0 m0", ras_empty, misalign_err); end
        trap_valid = 1'b1;
        trap_vec   = 32'h800;
        redirect(2'b01, 32'h900);
        trap_valid = 1'b0;
        checks++; if (PC !== 32'h800 || ras_empty !== 1'b1) begin
            errors++; $display("FAIL trap_over_redir got %h e%b want 00000800 e1", PC, ras_empty); end
        redirect(2'b10, 32'h600);
        checks++; if (PC !== 32'h600) begin errors++; $display("FAIL ret_after_flush got %h want %h", PC, 32'h600); end
        stall = 1'b0;
    endtask

    task automatic test_wrap_and_reset();
        redirect(2'b00, 32'hFFFF_FFFC);
        checks++; if (PCPlus !== 32'h0) begin errors++; $display("FAIL pcplus_wrap got %h want %h", PCPlus, 32'h0); end
        step();
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL pc_wrap got %h want %h", PC, 32'h0); end
        reset = 1'b0;
        redirect(2'b01, 32'h100);
        checks++; if (PC !== 32'h0 || ras_empty !== 1'b1 || pc_valid !== 1'b0) begin
            errors++; $display("FAIL reset_during_call got %h e%b v%b want 00000000 e1 v0", PC, ras_empty, pc_valid); end
        reset = 1'b1;
        step();
        checks++; if (PC !== 32'h0 || pc_valid !== 1'b1) begin
            errors++; $display("FAIL rerelease got %h v%b want 00000000 v1", PC, pc_valid); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stall();
        test_call_return();
        test_ras_full();
        test_misalign();
        test_wrap_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
